alu_operand_arbiter: RTL and testbench
======================================

# alu_operand_arbiter

Round-robin arbiter that shares the ALU's 4:1 8-bit operand multiplexer among four requesters (J, K, L, M). It drives the multiplexer select, captures the selected byte `mux_y` into a single-entry output register, and presents it downstream with a valid/ready handshake at up to one byte per cycle. An optional burst-lock mode lets one requester keep the multiplexer for consecutive transfers.

## Interface
- `MAX_BURST`, 4, maximum consecutive captures by one locked requester (2..15); only used with burst lock compiled in.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request; bit0=J, bit1=K, bit2=L, bit3=M; data must be stable on the mux input while asserted.
- `lock`  in  4  per-requester burst-lock request (burst lock only; ignored otherwise).
- `ack`  out  4  combinational one-hot; high in the cycle the requester's byte is captured.
- `sel`  out  2  combinational mux select: J=01, K=11, L=10, M=00; 00 when no capture.
- `mux_y`  in  8  multiplexer output, sampled at the capture edge.
- `out_valid`  out  1  output register holds a byte.
- `out_data`  out  8  captured byte.
- `out_src`  out  2  requester index (0=J..3=M) of `out_data`.
- `out_ready`  in  1  downstream accepts when `out_valid & out_ready`.

## Operation
- Output slot states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `can_cap` = EMPTY, or FULL with `out_ready`=1 (drain and refill in the same cycle).
- `cap` = `can_cap` & `|req`. Winner = first requester with `req` set, searching from index `ptr+1` mod 4 upward with wrap.
- On `cap`: `ack[winner]`=1, `sel`=encoding(winner); at the edge, `out_data`<=`mux_y`, `out_src`<=winner, `out_valid`<=1, `ptr`<=winner.
- FULL with `out_ready`=1 and no `req`: `out_valid`<=0 (to EMPTY); `out_data` and `out_src` keep their values.
- FULL with `out_ready`=0: hold everything; `ack`=0 and `sel`=00 regardless of `req`.
- Requester protocol: keep `req` asserted until `ack`; deassert or present new data the cycle after. Holding `req` yields a new capture every eligible cycle, subject to rotation.
- `ptr` is a 2-bit wrap-around counter; after a win by M (3), J (0) has top priority.

## Timing
- Reset values: `out_valid`=0, `out_data`=8'h00, `out_src`=0, `ptr`=3 (J first), burst count=0; the combinational outputs then give `ack`=0, `sel`=00.
- Reset mid-operation discards the held byte with no handshake; requests that are asserted are re-arbitrated in the first cycle after reset.
- Latency: `req` asserted in cycle N with the slot EMPTY gives `ack` in cycle N and `out_valid`=1 in cycle N+1.
- Throughput: one byte per cycle while `out_ready`=1 and any `req` is asserted.
- `out_data`/`out_src` are stable while `out_valid & ~out_ready`.
- Simultaneous requests: exactly one `ack` per cycle; a requester that remains asserted waits at most 3 captures.

## Configuration
- `ALU_ARB_BURST_LOCK_EN` defined: if the winner's `lock` bit is high at capture, the next capture goes to the same requester when its `req` is still high, and `ptr` is not advanced.
  - A 4-bit burst counter counts consecutive locked captures. At `MAX_BURST`, the lock is ignored for one arbitration and normal rotation resumes.
  - The counter clears when the lock drops, the requester's `req` drops, or the winner changes.
- Not defined: `lock` is unused, there is no burst counter, and rotation is pure round-robin.

## Test plan
- Reset, then `req`=0001 with J's byte 8'hA5 on `mux_y`, `out_ready`=1 → `sel`=01 and `ack`=0001 in the same cycle; next cycle `out_valid`=1, `out_data`=A5, `out_src`=0.
- `req`=1111 held, `out_ready`=1 → grant order J,K,L,M,J with `sel` 01,11,10,00,01 on consecutive cycles and a new byte every cycle.
- FULL with `out_ready`=0 for 5 cycles while `req`=0100 → `ack`=0, `out_data` unchanged; when `out_ready` rises → L is captured that cycle (`sel`=10) and `out_valid` stays 1.
- `rst` asserted while FULL with 8'h3C → next cycle `out_valid`=0, `out_data`=00, `ptr`=3; `req`=1000 afterwards → M is captured (`sel`=00, `out_src`=3).
- `ALU_ARB_BURST_LOCK_EN`, `MAX_BURST`=4: `req`=0011, `lock`=0001 → J captured 4 times in a row, then K once, then J resumes.
- Without the macro, same stimulus → J and K alternate every cycle.

Source files
------------

// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter for the ALU's shared 4:1 operand mux, with a single-entry valid/ready output slot.
// Optional burst lock is compiled in with `define ALU_ARB_BURST_LOCK_EN.
module alu_operand_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] lock,
  output logic [3:0] ack,
  output logic [1:0] sel,
  input  logic [7:0] mux_y,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [1:0] out_src,
  input  logic       out_ready
);

  logic [1:0] ptr;
  logic [1:0] rr_win;
  logic [1:0] win;
  logic [1:0] idx;
  logic       rr_found;
  logic       can_cap;
  logic       cap;

  assign can_cap = !out_valid || out_ready;
  assign cap     = can_cap && (|req);

  // Search from ptr+1 upward with wrap; offset 4 folds back onto ptr itself.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = ptr;
    idx      = ptr;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

`ifdef ALU_ARB_BURST_LOCK_EN
  logic [3:0] burst_cnt;
  logic       hold;

  // ptr always names the last winner, so it doubles as the lock owner.
  assign hold = (burst_cnt != 4'd0) && (burst_cnt < 4'(MAX_BURST)) && req[ptr] && lock[ptr];
  assign win  = hold ? ptr : rr_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= 4'd0;
    end else if (cap) begin
      if (lock[win] && (burst_cnt < 4'(MAX_BURST)))
        burst_cnt <= (win == ptr) ? burst_cnt + 4'd1 : 4'd1;
      else
        burst_cnt <= 4'd0;
    end else if ((burst_cnt != 4'd0) && !(req[ptr] && lock[ptr])) begin
      burst_cnt <= 4'd0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{lock, 4'(MAX_BURST)};
  assign win        = rr_win;
`endif

  always_comb begin
    ack = 4'b0000;
    sel = 2'b00;
    if (cap) begin
      ack[win] = 1'b1;
      case (win)
        2'd0:    sel = 2'b01;
        2'd1:    sel = 2'b11;
        2'd2:    sel = 2'b10;
        default: sel = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_src   <= 2'd0;
      ptr       <= 2'd3;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= win;
      ptr       <= win;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Directed table-driven bench for alu_operand_arbiter plus a burst-lock sequence.
module tb_alu_operand_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [3:0] ack;
  logic [1:0] sel;
  logic [7:0] mux_y;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;

  int passed = 0;
  int total  = 0;

  alu_operand_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .ack(ack), .sel(sel),
    .mux_y(mux_y), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [7:0] y;
    logic [3:0] e_ack;
    logic [1:0] e_sel;
    logic       e_vld;
    logic [7:0] e_data;
    logic [1:0] e_src;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic r, logic [3:0] rq, logic rd, logic [7:0] y,
                              logic [3:0] ea, logic [1:0] es, logic ev,
                              logic [7:0] ed, logic [1:0] esr);
    vec_t v;
    v.rst = r; v.req = rq; v.rdy = rd; v.y = y;
    v.e_ack = ea; v.e_sel = es; v.e_vld = ev; v.e_data = ed; v.e_src = esr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else
      passed++;
  endtask

  logic [3:0] exp_lock[7];

  initial begin
    // Each row is one cycle: inputs, then same-cycle ack/sel and the slot contents before the edge.
    vecs[0]  = mk(0, 4'b1111, 1, 8'h10, 4'b0001, 2'b01, 0, 8'h00, 2'd0);
    vecs[1]  = mk(0, 4'b1111, 1, 8'h11, 4'b0010, 2'b11, 1, 8'h10, 2'd0);
    vecs[2]  = mk(0, 4'b1111, 1, 8'h12, 4'b0100, 2'b10, 1, 8'h11, 2'd1);
    vecs[3]  = mk(0, 4'b1111, 1, 8'h13, 4'b1000, 2'b00, 1, 8'h12, 2'd2);
    vecs[4]  = mk(0, 4'b1111, 1, 8'h14, 4'b0001, 2'b01, 1, 8'h13, 2'd3);
    vecs[5]  = mk(0, 4'b0100, 0, 8'h3C, 4'b0000, 2'b00, 1, 8'h14, 2'd0);
    vecs[6]  = mk(0, 4'b0100, 0, 8'h3C, 4'b0000, 2'b00, 1, 8'h14, 2'd0);
    vecs[7]  = mk(0, 4'b0100, 0, 8'h3C, 4'b0000, 2'b00, 1, 8'h14, 2'd0);
    vecs[8]  = mk(0, 4'b0100, 0, 8'h3C, 4'b0000, 2'b00, 1, 8'h14, 2'd0);
    vecs[9]  = mk(0, 4'b0100, 0, 8'h3C, 4'b0000, 2'b00, 1, 8'h14, 2'd0);
    vecs[10] = mk(0, 4'b0100, 1, 8'h3C, 4'b0100, 2'b10, 1, 8'h14, 2'd0);
    vecs[11] = mk(0, 4'b0000, 0, 8'h00, 4'b0000, 2'b00, 1, 8'h3C, 2'd2);
    vecs[12] = mk(1, 4'b0000, 0, 8'h00, 4'b0000, 2'b00, 1, 8'h3C, 2'd2);
    vecs[13] = mk(0, 4'b1000, 1, 8'h77, 4'b1000, 2'b00, 0, 8'h00, 2'd0);
    vecs[14] = mk(0, 4'b0001, 1, 8'hA5, 4'b0001, 2'b01, 1, 8'h77, 2'd3);
    vecs[15] = mk(0, 4'b0000, 1, 8'h00, 4'b0000, 2'b00, 1, 8'hA5, 2'd0);
    vecs[16] = mk(0, 4'b0000, 0, 8'h00, 4'b0000, 2'b00, 0, 8'hA5, 2'd0);
    vecs[17] = mk(0, 4'b0010, 0, 8'h22, 4'b0010, 2'b11, 0, 8'hA5, 2'd0);
    vecs[18] = mk(0, 4'b0010, 0, 8'h23, 4'b0000, 2'b00, 1, 8'h22, 2'd1);
    vecs[19] = mk(0, 4'b0000, 1, 8'h00, 4'b0000, 2'b00, 1, 8'h22, 2'd1);

`ifdef ALU_ARB_BURST_LOCK_EN
    exp_lock = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
`else
    exp_lock = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif

    rst = 1'b1; req = 4'b0; lock = 4'b0; mux_y = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy; mux_y = vecs[i].y;
      #1;
      chk($sformatf("r%0d ack", i),   32'(ack),       32'(vecs[i].e_ack));
      chk($sformatf("r%0d sel", i),   32'(sel),       32'(vecs[i].e_sel));
      chk($sformatf("r%0d valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
      chk($sformatf("r%0d data", i),  32'(out_data),  32'(vecs[i].e_data));
      chk($sformatf("r%0d src", i),   32'(out_src),   32'(vecs[i].e_src));
    end

    // Burst-lock sequence from a fresh reset: J requests with lock, K without.
    @(negedge clk);
    rst = 1'b1; req = 4'b0; lock = 4'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req = 4'b0011; lock = 4'b0001; mux_y = 8'h40 + 8'(k);
      #1;
      chk($sformatf("lock%0d ack", k), 32'(ack), 32'(exp_lock[k]));
    end
    @(negedge clk);
    req = 4'b0; lock = 4'b0;
    #1;
    chk("lock last data", 32'(out_data), 32'h46);
    chk("lock last src",  32'(out_src),  32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
